bias_accum_relu_stage: RTL and testbench

- Sits directly downstream of a layer's 16-lane bias constant bank and its adder tree.
- Accumulates N_CHUNKS beats of per-lane adder-tree partial sums, then adds the per-lane 18-bit bias on the final beat.
- Saturates the result to 18 bits, applies optional ReLU, and presents one output vector per output pixel to the next layer's input buffer over a valid/ready handshake.

---
 rtl/bias_accum_relu_stage_pkg.sv | 35 +++
 rtl/bias_accum_relu_stage_lane.sv | 53 +++++
 rtl/bias_accum_relu_stage.sv | 86 ++++++++
 tb/tb_bias_accum_relu_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_accum_relu_stage_pkg.sv
// Shared constants and lane helpers for the bias/accumulate/ReLU output stage.
// Lane i of any packed vector lives at bits [18*(i+1)-1:18*i].
package bias_accum_relu_stage_pkg;

  localparam int DATA_W     = 18;
  localparam int SAT_IN_W   = 64;
  localparam int MAX_LANES  = 64;
  localparam int LANE_VEC_W = DATA_W * MAX_LANES;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 64'sd131071;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -64'sd131072;

  // Callers zero-extend their packed vector to LANE_VEC_W so one helper serves any lane count.
  function automatic logic [DATA_W-1:0] lane_slice(input logic [LANE_VEC_W-1:0] vec,
                                                   input int unsigned idx);
    return vec[idx*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] saturate_relu(input logic signed [SAT_IN_W-1:0] sum,
                                                      input logic reluEn);
    logic [DATA_W-1:0] clipped;
    if (sum > SAT_MAX) begin
      clipped = SAT_MAX[DATA_W-1:0];
    end else if (sum < SAT_MIN) begin
      clipped = SAT_MIN[DATA_W-1:0];
    end else begin
      clipped = sum[DATA_W-1:0];
    end
    if (reluEn && clipped[DATA_W-1]) begin
      clipped = '0;
    end
    return clipped;
  endfunction

endpackage

// File: rtl/bias_accum_relu_stage_lane.sv
// One lane: wrapping accumulator, then bias add, 18-bit saturation and optional ReLU
// on the final beat of an output pixel.
module bias_lane_acc
  import bias_accum_relu_stage_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter bit RELU_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fire_i,
  input  logic              firstBeat_i,
  input  logic              lastBeat_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] bias_i,
  output logic [DATA_W-1:0] result_o
);

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    accBase, dataExt, biasExt;
  logic signed [ACC_W:0]      sumWide;
  logic signed [SAT_IN_W-1:0] sumSat;
  logic [DATA_W-1:0]          result_q, result_d;

  // The first beat starts from zero rather than the stale accumulator, which also
  // makes a single-chunk configuration reduce to in + bias.
  always_comb begin
    dataExt  = {{(ACC_W-DATA_W){data_i[DATA_W-1]}}, data_i};
    biasExt  = {{(ACC_W-DATA_W){bias_i[DATA_W-1]}}, bias_i};
    accBase  = firstBeat_i ? '0 : acc_q;
    acc_d    = accBase + dataExt;
    sumWide  = {accBase[ACC_W-1], accBase} + {dataExt[ACC_W-1], dataExt}
             + {biasExt[ACC_W-1], biasExt};
    sumSat   = {{(SAT_IN_W-ACC_W-1){sumWide[ACC_W]}}, sumWide};
    result_d = saturate_relu(sumSat, RELU_EN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
    end else if (fire_i) begin
      if (lastBeat_i) begin
        result_q <= result_d;
      end else begin
        acc_q <= acc_d;
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/bias_accum_relu_stage.sv
// Output stage of a layer: accumulates N_CHUNKS partial-sum beats per lane, adds bias,
// saturates/ReLUs and hands the vector downstream over valid/ready.
module bias_accum_relu_stage
  import bias_accum_relu_stage_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int N_CHUNKS     = 4,
  parameter int ACC_W        = 24,
  parameter bit RELU_EN      = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_adder_tree*DATA_W-1:0] bias,
  input  logic [N_adder_tree*DATA_W-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [N_adder_tree*DATA_W-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNKS - 1);

  logic [CNT_W-1:0]      count_q, count_d;
  logic                  outValid_q, outValid_d;
  logic                  in_fire, out_fire, firstBeat, lastBeat;
  logic [LANE_VEC_W-1:0] biasWide, dataWide;

  // A held output blocks every lane at once, so accumulators and count freeze together.
  assign in_ready  = ~outValid_q | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = outValid_q & out_ready;
  assign firstBeat = (count_q == '0);
  assign lastBeat  = (count_q == LAST_CNT);
  assign busy      = (count_q != '0);
  assign out_valid = outValid_q;

  assign biasWide = LANE_VEC_W'(bias);
  assign dataWide = LANE_VEC_W'(in_data);

  // A final beat landing in the same cycle as out_fire refills the output with no bubble.
  always_comb begin
    count_d    = count_q;
    outValid_d = outValid_q;
    if (out_fire) begin
      outValid_d = 1'b0;
    end
    if (in_fire) begin
      if (lastBeat) begin
        count_d    = '0;
        outValid_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      outValid_q <= outValid_d;
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_lane_acc #(
      .ACC_W   (ACC_W),
      .RELU_EN (RELU_EN)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .fire_i      (in_fire),
      .firstBeat_i (firstBeat),
      .lastBeat_i  (lastBeat),
      .data_i      (lane_slice(dataWide, i)),
      .bias_i      (lane_slice(biasWide, i)),
      .result_o    (out_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_bias_accum_relu_stage.sv
// Directed bench: default stage (4 chunks, ReLU) plus a 1-chunk, no-ReLU stage
// for saturation and back-to-back output checks.
module tb_bias_accum_relu_stage;

  localparam int VW = 16 * 18;

  logic          clk;
  logic          rst_n;
  logic [VW-1:0] mBias, mInData, mOutData;
  logic          mInValid, mInReady, mOutValid, mOutReady, mBusy;
  logic [VW-1:0] sBias, sInData, sOutData;
  logic          sInValid, sInReady, sOutValid, sOutReady, sBusy;
  logic [VW-1:0] d, b, expV;
  int            checks;
  int            errors;

  bias_accum_relu_stage dutMain (
    .clk       (clk),
    .rst_n     (rst_n),
    .bias      (mBias),
    .in_data   (mInData),
    .in_valid  (mInValid),
    .in_ready  (mInReady),
    .out_data  (mOutData),
    .out_valid (mOutValid),
    .out_ready (mOutReady),
    .busy      (mBusy)
  );

  bias_accum_relu_stage #(
    .N_adder_tree (16),
    .N_CHUNKS     (1),
    .ACC_W        (24),
    .RELU_EN      (1'b0)
  ) dutSat (
    .clk       (clk),
    .rst_n     (rst_n),
    .bias      (sBias),
    .in_data   (sInData),
    .in_valid  (sInValid),
    .in_ready  (sInReady),
    .out_data  (sOutData),
    .out_valid (sOutValid),
    .out_ready (sOutReady),
    .busy      (sBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [VW-1:0] data, input logic [VW-1:0] bv);
    mInValid = v;
    mInData  = data;
    mBias    = bv;
  endtask

  task automatic applySatStimulus(input logic v, input logic [VW-1:0] data, input logic [VW-1:0] bv);
    sInValid = v;
    sInData  = data;
    sBias    = bv;
  endtask

  task automatic checkOutput(input string tag, input logic [VW-1:0] observed, input logic [VW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    mOutReady = 1'b1;
    sOutReady = 1'b1;
    applyStimulus(1'b0, '0, '0);
    applySatStimulus(1'b0, '0, '0);
    #1 rst_n = 1'b0;
    #11;
    checkFlag("reset out_valid", mOutValid, 1'b0);
    checkFlag("reset busy", mBusy, 1'b0);
    checkOutput("reset out_data", mOutData, '0);
    checkFlag("reset in_ready", mInReady, 1'b1);
    checkFlag("reset sat out_valid", sOutValid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic accumulation");
    d = '0;
    d[0 +: 18] = 18'd100;
    applyStimulus(1'b1, d, '0);
    checkFlag("busy before beat1", mBusy, 1'b0);
    tick();
    checkFlag("busy beat2", mBusy, 1'b1);
    checkFlag("out_valid after beat1", mOutValid, 1'b0);
    tick();
    checkFlag("busy beat3", mBusy, 1'b1);
    tick();
    checkFlag("busy beat4", mBusy, 1'b1);
    checkFlag("out_valid after beat3", mOutValid, 1'b0);
    tick();
    expV = '0;
    expV[0 +: 18] = 18'd400;
    checkFlag("out_valid after beat4", mOutValid, 1'b1);
    checkFlag("busy after beat4", mBusy, 1'b0);
    checkOutput("sum 4x100", mOutData, expV);

    $display("[TB] relu negative");
    b = '0;
    b[90 +: 18] = 18'd10;
    d = '0;
    d[36 +: 18] = 18'd1000;
    d[90 +: 18] = 18'(-20);
    applyStimulus(1'b1, d, b);
    tick();
    checkFlag("out_valid cleared", mOutValid, 1'b0);
    tick();
    tick();
    d[90 +: 18] = 18'd10;
    applyStimulus(1'b1, d, b);
    tick();
    expV = '0;
    expV[36 +: 18] = 18'd4000;
    checkFlag("relu vec valid", mOutValid, 1'b1);
    checkOutput("relu negative", mOutData, expV);

    $display("[TB] relu positive");
    d = '0;
    d[90 +: 18] = 18'd20;
    applyStimulus(1'b1, d, b);
    tick();
    d[90 +: 18] = 18'd10;
    applyStimulus(1'b1, d, b);
    tick();
    tick();
    tick();
    expV = '0;
    expV[90 +: 18] = 18'd60;
    checkFlag("relu pos valid", mOutValid, 1'b1);
    checkOutput("relu positive", mOutData, expV);

    $display("[TB] backpressure");
    mOutReady = 1'b0;
    d = '0;
    d[0 +: 18] = 18'd1;
    applyStimulus(1'b1, d, b);
    #1;
    checkFlag("stall in_ready", mInReady, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("stall out_data", mOutData, expV);
      checkFlag("stall out_valid", mOutValid, 1'b1);
      checkFlag("stall busy", mBusy, 1'b0);
    end
    mOutReady = 1'b1;
    #1;
    checkFlag("release in_ready", mInReady, 1'b1);
    tick();
    checkFlag("release out_valid", mOutValid, 1'b0);
    checkFlag("held beat accepted", mBusy, 1'b1);
    tick();
    tick();
    tick();
    expV = '0;
    expV[0 +: 18]  = 18'd4;
    expV[90 +: 18] = 18'd10;
    checkFlag("post-stall valid", mOutValid, 1'b1);
    checkOutput("post-stall vector", mOutData, expV);
    applyStimulus(1'b0, '0, '0);

    $display("[TB] saturation and back-to-back");
    d = '0;
    b = '0;
    d[54 +: 18] = 18'(-100000);
    b[54 +: 18] = 18'(-53076);
    applySatStimulus(1'b1, d, b);
    tick();
    expV = '0;
    expV[54 +: 18] = 18'h20000;
    checkFlag("sat neg valid", sOutValid, 1'b1);
    checkOutput("sat negative", sOutData, expV);
    checkFlag("sat busy", sBusy, 1'b0);
    d[54 +: 18] = 18'd131071;
    b[54 +: 18] = 18'd1;
    applySatStimulus(1'b1, d, b);
    tick();
    expV[54 +: 18] = 18'h1FFFF;
    checkFlag("sat pos valid", sOutValid, 1'b1);
    checkOutput("sat positive", sOutData, expV);
    d[54 +: 18] = 18'd10;
    d[0 +: 18]  = 18'(-5);
    b[54 +: 18] = 18'(-53076);
    applySatStimulus(1'b1, d, b);
    tick();
    expV[54 +: 18] = 18'h330B6;
    expV[0 +: 18]  = 18'h3FFFB;
    checkFlag("third b2b valid", sOutValid, 1'b1);
    checkOutput("no relu negative", sOutData, expV);
    applySatStimulus(1'b0, d, b);
    tick();
    checkFlag("sat drain", sOutValid, 1'b0);
    sOutReady = 1'b0;
    d = '0;
    d[54 +: 18] = 18'd1;
    applySatStimulus(1'b1, d, '0);
    tick();
    applySatStimulus(1'b0, '0, '0);
    expV = '0;
    expV[54 +: 18] = 18'd1;
    checkFlag("sat held valid", sOutValid, 1'b1);
    checkOutput("sat held data", sOutData, expV);

    $display("[TB] reset mid-accumulation");
    d = '0;
    d[0 +: 18] = 18'd50;
    applyStimulus(1'b1, d, '0);
    tick();
    tick();
    checkFlag("partial busy", mBusy, 1'b1);
    #3;
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0);
    #1;
    checkFlag("async busy", mBusy, 1'b0);
    checkFlag("async out_valid", mOutValid, 1'b0);
    checkOutput("async out_data", mOutData, '0);
    checkFlag("async sat out_valid", sOutValid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    d = '0;
    d[0 +: 18] = 18'd7;
    applyStimulus(1'b1, d, '0);
    tick();
    tick();
    tick();
    tick();
    applyStimulus(1'b0, '0, '0);
    expV = '0;
    expV[0 +: 18] = 18'd28;
    checkFlag("post-reset valid", mOutValid, 1'b1);
    checkOutput("post-reset sum", mOutData, expV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
